path_history_reg: RTL and testbench
===================================

# path_history_reg

Global path-history shift register for the Alpha 21264-style tournament branch predictor. Every clock it shifts the current branch prediction/outcome bit into a 12-bit history. The history (`PHresult`) indexes the global predictor and choice predictor tables. The block is purely sequential, with no handshake: one bit enters per clock edge.

## Interface

Parameters:
- `HIST_LEN`, default 12: history length in bits. The port width of `PHresult` is `HIST_LEN`.

Ports:
- `clock` — input, 1 bit. The single clock. All state updates on its rising edge.
- `reset` — input, 1 bit. Reset is asynchronous and active-low.
- `Prediction` — input, 1 bit. Branch direction to record: 1 = taken, 0 = not taken.
- `PHresult` — output, `HIST_LEN` bits. Current path history. Bit 0 is the newest entry; bit `HIST_LEN-1` is the oldest.

## Operation

- State is one `HIST_LEN`-bit register. `PHresult` is driven directly from it, with no combinational path from `Prediction`.
- On each rising edge of `clock` with `reset` high: `PHresult <= {PHresult[HIST_LEN-2:0], Prediction}`.
  - The oldest bit (MSB) is discarded.
  - The new bit enters at the LSB.
- There is no enable. The register shifts on every clock edge while out of reset. A value held on `Prediction` for N edges is inserted N times.
- While `reset` is low, the register is held at all zeros.
  - `Prediction` is ignored during reset and may be X/Z.
  - X on `Prediction` during reset must not propagate into `PHresult`.
- If `Prediction` is X/Z outside reset, X enters bit 0 and shifts through normally. This is not a design error, but the environment must avoid it.

## Timing

- Reset value: `PHresult = 0` (12'h000).
- Reset assertion: `PHresult` clears to zero immediately, without waiting for a clock edge. This applies at any point, including mid-sequence.
- Reset deassertion: the first rising edge with `reset` high performs the first shift.
- Latency is 1 cycle. `Prediction`, sampled at rising edge k, appears in `PHresult[0]` immediately after edge k.
- After `HIST_LEN` further edges, that bit has shifted out entirely.
- Setup and hold are referenced to the rising edge. The stimulus changes `Prediction` on the falling edge.
- Reset mid-operation discards all history, with no partial state kept. History refills from zero after deassertion.

## Test plan

1. **Reset:** drive `reset` = 0 for 3 cycles with `Prediction` = X.
   - `PHresult` = 12'h000 throughout, and is zero before the first clock edge.
2. **All-taken fill:** release reset and hold `Prediction` = 1 for 30 edges.
   - After edge k (k ≤ 12), `PHresult` = (1<<k)-1: 12'h001, 12'h003, 12'h007, …
   - From edge 12 on, `PHresult` = 12'hFFF and saturates there.
3. **All-not-taken drain:** from 12'hFFF, hold `Prediction` = 0 for 30 edges.
   - Sequence is 12'hFFE, 12'hFFC, 12'hFF8, …, reaching 12'h000 at edge 12 and staying there.
4. **Alternating pairs:** drive pattern 1,1,0,0 repeated, one bit per edge, starting from 12'h000 for 4 edges of 1.
   - Steady state cycles through 12'h333, 12'h666, 12'hCCC, 12'h999 with period 4.
5. **Single-bit walk:** from 12'h000, apply one edge with `Prediction` = 1, then zeros.
   - `PHresult` = 12'h001, 12'h002, …, 12'h800, then 12'h000 after edge 13.
6. **Asynchronous reset mid-stream:** with `PHresult` = 12'hFFF, pull `reset` low between clock edges.
   - `PHresult` becomes 12'h000 before the next rising edge.
   - It stays 12'h000 while reset is low, regardless of `Prediction`.
   - The first edge after release with `Prediction` = 1 gives 12'h001.

Source files
------------

// File: rtl/path_history_reg.sv
// Global path-history shift register for a tournament branch predictor.
// One prediction bit enters at the LSB on every rising clock edge.
module path_history_reg #(
  parameter int HIST_LEN = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                Prediction,
  output logic [HIST_LEN-1:0] PHresult
);

  logic [HIST_LEN-1:0] hist;

  // Reset clears the history at once; Prediction is never sampled while reset is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist <= '0;
    end else begin
      hist <= {hist[HIST_LEN-2:0], Prediction};
    end
  end

  assign PHresult = hist;

endmodule

// File: tb/tb_path_history_reg.sv
// Self-checking bench for path_history_reg: per-scenario tasks with a queue scoreboard.
module tb_path_history_reg;

  logic        clock = 1'b0;
  logic        reset;
  logic        Prediction;
  logic [11:0] PHresult;

  int checks = 0;
  int errors = 0;
  logic [11:0] sb[$];

  path_history_reg #(.HIST_LEN(12)) dut (
    .clock     (clock),
    .reset     (reset),
    .Prediction(Prediction),
    .PHresult  (PHresult)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    logic [11:0] exp;
    reset = 1'b0;
    Prediction = 1'bx;
    #1;
    checks++;
    if (PHresult !== 12'h000) begin
      errors++;
      $display("FAIL reset_pre_edge got %h want %h", PHresult, 12'h000);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      sb.push_back(12'h000);
      @(posedge clock);
      #1;
      exp = sb.pop_front();
      checks++;
      if (PHresult !== exp) begin
        errors++;
        $display("FAIL reset_hold cycle %0d got %h want %h", i, PHresult, exp);
      end
      $display("reset cycle %0d PHresult %h", i, PHresult);
    end
  endtask

  task automatic test_fill();
    logic [11:0] exp;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      reset = 1'b1;
      Prediction = 1'b1;
      sb.push_back((k >= 12) ? 12'hFFF : 12'((1 << k) - 1));
      @(posedge clock);
      #1;
      exp = sb.pop_front();
      checks++;
      if (PHresult !== exp) begin
        errors++;
        $display("FAIL fill edge %0d got %h want %h", k, PHresult, exp);
      end
      $display("fill edge %0d PHresult %h", k, PHresult);
    end
  endtask

  task automatic test_drain();
    logic [11:0] exp;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      Prediction = 1'b0;
      sb.push_back((k >= 12) ? 12'h000 : 12'(12'hFFF << k));
      @(posedge clock);
      #1;
      exp = sb.pop_front();
      checks++;
      if (PHresult !== exp) begin
        errors++;
        $display("FAIL drain edge %0d got %h want %h", k, PHresult, exp);
      end
      $display("drain edge %0d PHresult %h", k, PHresult);
    end
  endtask

  task automatic test_pairs();
    logic [11:0] exp;
    logic [11:0] early;
    logic [11:0] steady[4];
    logic        p;
    steady[0] = 12'hCCC;
    steady[1] = 12'h999;
    steady[2] = 12'h333;
    steady[3] = 12'h666;
    early = 12'h000;
    for (int n = 1; n <= 24; n++) begin
      p = (((n - 1) % 4) < 2);
      early = {early[10:0], p};
      @(negedge clock);
      Prediction = p;
      sb.push_back((n >= 12) ? steady[(n - 12) % 4] : early);
      @(posedge clock);
      #1;
      exp = sb.pop_front();
      checks++;
      if (PHresult !== exp) begin
        errors++;
        $display("FAIL pairs edge %0d got %h want %h", n, PHresult, exp);
      end
      $display("pairs edge %0d in %b PHresult %h", n, p, PHresult);
    end
  endtask

  task automatic test_walk();
    logic [11:0] exp;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      Prediction = 1'b0;
      @(posedge clock);
    end
    #1;
    checks++;
    if (PHresult !== 12'h000) begin
      errors++;
      $display("FAIL walk_clear got %h want %h", PHresult, 12'h000);
    end
    for (int k = 1; k <= 13; k++) begin
      @(negedge clock);
      Prediction = (k == 1);
      sb.push_back((k <= 12) ? 12'(1 << (k - 1)) : 12'h000);
      @(posedge clock);
      #1;
      exp = sb.pop_front();
      checks++;
      if (PHresult !== exp) begin
        errors++;
        $display("FAIL walk edge %0d got %h want %h", k, PHresult, exp);
      end
      $display("walk edge %0d PHresult %h", k, PHresult);
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] exp;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      Prediction = 1'b1;
      @(posedge clock);
    end
    #1;
    checks++;
    if (PHresult !== 12'hFFF) begin
      errors++;
      $display("FAIL async_prefill got %h want %h", PHresult, 12'hFFF);
    end
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (PHresult !== 12'h000) begin
      errors++;
      $display("FAIL async_clear_before_edge got %h want %h", PHresult, 12'h000);
    end
    $display("async reset asserted PHresult %h", PHresult);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      Prediction = (i == 1) ? 1'bx : 1'b1;
      sb.push_back(12'h000);
      @(posedge clock);
      #1;
      exp = sb.pop_front();
      checks++;
      if (PHresult !== exp) begin
        errors++;
        $display("FAIL async_hold cycle %0d got %h want %h", i, PHresult, exp);
      end
      $display("async hold cycle %0d PHresult %h", i, PHresult);
    end
    @(negedge clock);
    reset = 1'b1;
    Prediction = 1'b1;
    sb.push_back(12'h001);
    @(posedge clock);
    #1;
    exp = sb.pop_front();
    checks++;
    if (PHresult !== exp) begin
      errors++;
      $display("FAIL async_release got %h want %h", PHresult, exp);
    end
    $display("async release PHresult %h", PHresult);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_pairs();
    test_walk();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
